// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - request, ALU drive and response signals of alu_sequencer
interface alu_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  reqValid;
    logic                  reqReady;
    logic [4:0]            reqOp;
    logic [DATA_WIDTH-1:0] reqA;
    logic [DATA_WIDTH-1:0] reqB;
    logic [15:0]           reqImm;

    logic [4:0]            opCode;
    logic [DATA_WIDTH-1:0] dataA;
    logic [DATA_WIDTH-1:0] dataB;
    logic [DATA_WIDTH-1:0] dataC;
    logic                  zero;
    logic                  overflow;
    logic                  error;

    logic                  rspValid;
    logic                  rspReady;
    logic [DATA_WIDTH-1:0] rspData;
    logic                  rspZero;
    logic                  rspOverflow;
    logic                  rspError;
    logic                  rspIllegal;

    modport master (
        output reqValid, reqOp, reqA, reqB, reqImm, dataC, zero, overflow, error, rspReady,
        input  reqReady, opCode, dataA, dataB,
        input  rspValid, rspData, rspZero, rspOverflow, rspError, rspIllegal
    );

    modport slave (
        input  reqValid, reqOp, reqA, reqB, reqImm, dataC, zero, overflow, error, rspReady,
        output reqReady, opCode, dataA, dataB,
        output rspValid, rspData, rspZero, rspOverflow, rspError, rspIllegal
    );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - drives an external ALU, waits SETTLE_CYCLES, returns the result
// Optional sticky error flag enabled by defining ALU_SEQ_STICKY_EN.
module alu_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clock,
    input  logic reset,
`ifdef ALU_SEQ_STICKY_EN
    input  logic stickyClr,
    output logic stickyErr,
`endif
    alu_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [4:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_zero_q, rsp_zero_d;
    logic                  rsp_ovf_q, rsp_ovf_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_ill_q, rsp_ill_d;
    logic [DATA_WIDTH-1:0] b_sel;

    logic accept;
    logic legal;
    logic load;
    logic capture;

    assign accept  = (state_q == IDLE) && bus.reqValid;
    assign legal   = (bus.reqOp <= 5'h13);
    assign load    = accept && legal;
    assign capture = (state_q == SETTLE) && (cnt_q == 4'd1);

    // Immediate-form ops take the zero-extended immediate; Not ignores its second operand.
    always_comb begin
        case (bus.reqOp)
            5'h01, 5'h03, 5'h05, 5'h07,
            5'h0A, 5'h0C, 5'h0E, 5'h13: b_sel = DATA_WIDTH'(bus.reqImm);
            5'h0F:                      b_sel = '0;
            default:                    b_sel = bus.reqB;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = legal ? SETTLE : RESP;
            SETTLE:  if (cnt_q == 4'd1) state_d = RESP;
            RESP:    if (bus.rspReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.reqReady = (state_q == IDLE);
        bus.rspValid = (state_q == RESP);
    end

    always_comb begin
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rsp_ovf_d  = rsp_ovf_q;
        rsp_err_d  = rsp_err_q;
        rsp_ill_d  = rsp_ill_q;
        if (load) begin
            op_d  = bus.reqOp;
            a_d   = bus.reqA;
            b_d   = b_sel;
            cnt_d = 4'(SETTLE_CYCLES);
        end else if (accept) begin
            // Illegal op: ALU drive is left untouched and the response is synthesized here.
            rsp_data_d = '0;
            rsp_zero_d = 1'b0;
            rsp_ovf_d  = 1'b0;
            rsp_err_d  = 1'b0;
            rsp_ill_d  = 1'b1;
        end
        if (state_q == SETTLE) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (capture) begin
            rsp_data_d = bus.dataC;
            rsp_zero_d = bus.zero;
            rsp_ovf_d  = bus.overflow;
            rsp_err_d  = bus.error;
            rsp_ill_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_ill_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_ovf_q  <= rsp_ovf_d;
            rsp_err_q  <= rsp_err_d;
            rsp_ill_q  <= rsp_ill_d;
        end
    end

    assign bus.opCode      = op_q;
    assign bus.dataA       = a_q;
    assign bus.dataB       = b_q;
    assign bus.rspData     = rsp_data_q;
    assign bus.rspZero     = rsp_zero_q;
    assign bus.rspOverflow = rsp_ovf_q;
    assign bus.rspError    = rsp_err_q;
    assign bus.rspIllegal  = rsp_ill_q;

`ifdef ALU_SEQ_STICKY_EN
    logic sticky_q, sticky_d, sticky_set;

    assign sticky_set = (accept && !legal) || (capture && (bus.error || bus.overflow));

    // A new error in the same cycle as a clear request must not be lost.
    always_comb begin
        sticky_d = sticky_q;
        if (sticky_set) begin
            sticky_d = 1'b1;
        end else if (stickyClr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign stickyErr = sticky_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
module tb_alu_sequencer;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    alu_sequencer_if #(.DATA_WIDTH(32)) bus1 ();
    alu_sequencer_if #(.DATA_WIDTH(32)) bus4 ();

`ifdef ALU_SEQ_STICKY_EN
    logic stickyClr1, stickyErr1, stickyClr4, stickyErr4;
`endif

    alu_sequencer #(.DATA_WIDTH(32), .SETTLE_CYCLES(1)) dut1 (
        .clock     (clock),
        .reset     (reset),
`ifdef ALU_SEQ_STICKY_EN
        .stickyClr (stickyClr1),
        .stickyErr (stickyErr1),
`endif
        .bus       (bus1)
    );

    alu_sequencer #(.DATA_WIDTH(32), .SETTLE_CYCLES(4)) dut4 (
        .clock     (clock),
        .reset     (reset),
`ifdef ALU_SEQ_STICKY_EN
        .stickyClr (stickyClr4),
        .stickyErr (stickyErr4),
`endif
        .bus       (bus4)
    );

    always #5 clock = ~clock;

    // Called at a negedge with dut1 idle; returns at the negedge after the accept edge.
    task automatic issue1(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [15:0] imm);
        bus1.reqValid = 1'b1;
        bus1.reqOp    = op;
        bus1.reqA     = a;
        bus1.reqB     = b;
        bus1.reqImm   = imm;
        @(posedge clock);
        @(negedge clock);
        bus1.reqValid = 1'b0;
    endtask

    task automatic drain1();
        bus1.rspReady = 1'b1;
        @(negedge clock);
        bus1.rspReady = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (bus1.reqReady !== 1'b1) begin errors++; $display("FAIL reset_reqReady got=%0b exp=1", bus1.reqReady); end
        checks++; if (bus1.rspValid !== 1'b0) begin errors++; $display("FAIL reset_rspValid got=%0b exp=0", bus1.rspValid); end
        checks++; if ({bus1.opCode, bus1.dataA, bus1.dataB} !== 69'd0) begin errors++; $display("FAIL reset_drive got=%0h/%0h/%0h exp=0", bus1.opCode, bus1.dataA, bus1.dataB); end
        checks++; if ({bus1.rspData, bus1.rspZero, bus1.rspOverflow, bus1.rspError, bus1.rspIllegal} !== 36'd0) begin errors++; $display("FAIL reset_rsp got=%0h exp=0", bus1.rspData); end
`ifdef ALU_SEQ_STICKY_EN
        checks++; if (stickyErr1 !== 1'b0) begin errors++; $display("FAIL reset_sticky got=%0b exp=0", stickyErr1); end
`endif
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_add();
        bus1.dataC = 32'd12; bus1.zero = 1'b0; bus1.overflow = 1'b0; bus1.error = 1'b0;
        issue1(5'h00, 32'd5, 32'd7, 16'h1234);
        checks++; if (bus1.rspValid !== 1'b0) begin errors++; $display("FAIL add_early_valid got=%0b exp=0", bus1.rspValid); end
        checks++; if ({bus1.dataA, bus1.dataB} !== {32'd5, 32'd7}) begin errors++; $display("FAIL add_operands got=%0h/%0h exp=5/7", bus1.dataA, bus1.dataB); end
        @(negedge clock);
        checks++; if (bus1.rspValid !== 1'b1) begin errors++; $display("FAIL add_valid got=%0b exp=1", bus1.rspValid); end
        checks++; if (bus1.rspData !== 32'd12) begin errors++; $display("FAIL add_data got=%0h exp=c", bus1.rspData); end
        checks++; if ({bus1.rspZero, bus1.rspIllegal, bus1.reqReady} !== 3'b000) begin errors++; $display("FAIL add_flags got=%b exp=000", {bus1.rspZero, bus1.rspIllegal, bus1.reqReady}); end
        drain1();
        checks++; if ({bus1.rspValid, bus1.reqReady} !== 2'b01) begin errors++; $display("FAIL add_release got=%b exp=01", {bus1.rspValid, bus1.reqReady}); end
    endtask

    task automatic test_immediate();
        issue1(5'h01, 32'h11, 32'hFFFF_FFFF, 16'h8001);
        checks++; if (bus1.dataB !== 32'h0000_8001) begin errors++; $display("FAIL imm_dataB got=%0h exp=8001", bus1.dataB); end
        checks++; if (bus1.opCode !== 5'h01) begin errors++; $display("FAIL imm_opCode got=%0h exp=1", bus1.opCode); end
        @(negedge clock); drain1();
        issue1(5'h0F, 32'hA5, 32'h1234, 16'hFFFF);
        checks++; if (bus1.dataB !== 32'h0) begin errors++; $display("FAIL not_dataB got=%0h exp=0", bus1.dataB); end
        @(negedge clock); drain1();
        issue1(5'h13, 32'h1, 32'hFFFF_FFFF, 16'hFFFF);
        checks++; if (bus1.dataB !== 32'h0000_FFFF) begin errors++; $display("FAIL imm13_dataB got=%0h exp=ffff", bus1.dataB); end
        @(negedge clock);
        checks++; if ({bus1.rspValid, bus1.rspIllegal} !== 2'b10) begin errors++; $display("FAIL op13_legal got=%b exp=10", {bus1.rspValid, bus1.rspIllegal}); end
        drain1();
        issue1(5'h12, 32'h3, 32'hCAFE_F00D, 16'h0007);
        checks++; if (bus1.dataB !== 32'hCAFE_F00D) begin errors++; $display("FAIL op12_dataB got=%0h exp=cafef00d", bus1.dataB); end
        @(negedge clock); drain1();
    endtask

    task automatic test_illegal();
        bus1.dataC = 32'hDEAD; bus1.zero = 1'b1; bus1.overflow = 1'b1; bus1.error = 1'b1;
        issue1(5'h15, 32'h99, 32'h88, 16'h7);
        checks++; if ({bus1.rspValid, bus1.rspIllegal} !== 2'b11) begin errors++; $display("FAIL ill15_valid got=%b exp=11", {bus1.rspValid, bus1.rspIllegal}); end
        checks++; if ({bus1.rspData, bus1.rspZero, bus1.rspOverflow, bus1.rspError} !== 35'd0) begin errors++; $display("FAIL ill15_rsp got=%0h exp=0", bus1.rspData); end
        checks++; if ({bus1.opCode, bus1.dataA} !== {5'h12, 32'h3}) begin errors++; $display("FAIL ill15_drive got=%0h/%0h exp=12/3", bus1.opCode, bus1.dataA); end
        drain1();
        issue1(5'h14, 32'h99, 32'h88, 16'h7);
        checks++; if ({bus1.rspValid, bus1.rspIllegal, bus1.opCode} !== {2'b11, 5'h12}) begin errors++; $display("FAIL ill14 got=%b/%0h exp=11/12", {bus1.rspValid, bus1.rspIllegal}, bus1.opCode); end
        drain1();
        bus1.dataC = 32'h0; bus1.zero = 1'b0; bus1.overflow = 1'b0; bus1.error = 1'b0;
    endtask

    task automatic test_backpressure();
        bus1.dataC = 32'h0; bus1.zero = 1'b1; bus1.overflow = 1'b1;
        issue1(5'h02, 32'h7, 32'h7, 16'h0);
        @(negedge clock);
        bus1.dataC = 32'h55; bus1.zero = 1'b0; bus1.overflow = 1'b0;
        bus1.reqValid = 1'b1; bus1.reqOp = 5'h03; bus1.reqA = 32'h77;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus1.rspValid, bus1.reqReady, bus1.rspData, bus1.rspZero, bus1.rspOverflow, bus1.opCode} !==
                {1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 5'h02}) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got=%b%b/%0h/%b%b/%0h exp=10/0/11/2", i, bus1.rspValid,
                         bus1.reqReady, bus1.rspData, bus1.rspZero, bus1.rspOverflow, bus1.opCode);
            end
            @(negedge clock);
        end
        bus1.rspReady = 1'b1;
        @(negedge clock);
        checks++; if ({bus1.reqReady, bus1.rspValid, bus1.opCode} !== {2'b10, 5'h02}) begin errors++; $display("FAIL bp_release got=%b/%0h exp=10/2", {bus1.reqReady, bus1.rspValid}, bus1.opCode); end
        bus1.reqValid = 1'b0; bus1.rspReady = 1'b0;
        bus1.dataC = 32'h0; bus1.zero = 1'b0; bus1.overflow = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_settle4();
        bus4.dataC = 32'h1234_5678;
        bus4.reqValid = 1'b1; bus4.reqOp = 5'h00; bus4.reqA = 32'h1; bus4.reqB = 32'h2;
        @(posedge clock);
        @(negedge clock);
        bus4.reqValid = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (bus4.rspValid !== 1'b0) begin errors++; $display("FAIL s4_early got=%0b exp=0", bus4.rspValid); end
        @(negedge clock);
        checks++; if ({bus4.rspValid, bus4.rspData} !== {1'b1, 32'h1234_5678}) begin errors++; $display("FAIL s4_resp got=%0b/%0h exp=1/12345678", bus4.rspValid, bus4.rspData); end
        bus4.rspReady = 1'b1;
        @(negedge clock);
        bus4.rspReady = 1'b0;
    endtask

    task automatic test_reset_mid_settle();
        bit seen;
        seen = 1'b0;
        bus4.reqValid = 1'b1; bus4.reqOp = 5'h00; bus4.reqA = 32'h3; bus4.reqB = 32'h4;
        @(posedge clock);
        @(negedge clock);
        bus4.reqValid = 1'b0;
        checks++; if ({bus4.rspValid, bus4.dataA} !== {1'b0, 32'h3}) begin errors++; $display("FAIL rms_pre got=%0b/%0h exp=0/3", bus4.rspValid, bus4.dataA); end
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        checks++; if ({bus4.reqReady, bus4.rspValid} !== 2'b10) begin errors++; $display("FAIL rms_hs got=%b exp=10", {bus4.reqReady, bus4.rspValid}); end
        checks++; if ({bus4.opCode, bus4.dataA, bus4.dataB, bus4.rspData} !== 101'd0) begin errors++; $display("FAIL rms_outputs got=%0h/%0h/%0h/%0h exp=0", bus4.opCode, bus4.dataA, bus4.dataB, bus4.rspData); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (bus4.rspValid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rms_no_valid got=%0b exp=0", seen); end
    endtask

    task automatic test_reset_in_resp();
        bus1.dataC = 32'hAB;
        issue1(5'h00, 32'h1, 32'h2, 16'h0);
        @(negedge clock);
        checks++; if (bus1.rspValid !== 1'b1) begin errors++; $display("FAIL rir_pre got=%0b exp=1", bus1.rspValid); end
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        checks++; if ({bus1.rspValid, bus1.reqReady, bus1.rspData} !== {2'b01, 32'h0}) begin errors++; $display("FAIL rir_post got=%b/%0h exp=01/0", {bus1.rspValid, bus1.reqReady}, bus1.rspData); end
        bus1.dataC = 32'h0;
        @(negedge clock);
    endtask

`ifdef ALU_SEQ_STICKY_EN
    task automatic test_sticky();
        bus1.dataC = 32'h0; bus1.error = 1'b1;
        issue1(5'h06, 32'd10, 32'd0, 16'h0);
        @(negedge clock);
        checks++; if ({stickyErr1, bus1.rspError} !== 2'b11) begin errors++; $display("FAIL sticky_set got=%b exp=11", {stickyErr1, bus1.rspError}); end
        drain1();
        bus1.error = 1'b0; bus1.dataC = 32'd12;
        issue1(5'h00, 32'd5, 32'd7, 16'h0);
        @(negedge clock); drain1();
        checks++; if (stickyErr1 !== 1'b1) begin errors++; $display("FAIL sticky_persist got=%0b exp=1", stickyErr1); end
        stickyClr1 = 1'b1;
        @(negedge clock);
        stickyClr1 = 1'b0;
        checks++; if (stickyErr1 !== 1'b0) begin errors++; $display("FAIL sticky_clear got=%0b exp=0", stickyErr1); end
        bus1.overflow = 1'b1;
        issue1(5'h00, 32'd1, 32'd1, 16'h0);
        stickyClr1 = 1'b1;
        @(negedge clock);
        stickyClr1 = 1'b0;
        checks++; if (stickyErr1 !== 1'b1) begin errors++; $display("FAIL sticky_set_wins got=%0b exp=1", stickyErr1); end
        drain1();
        bus1.overflow = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        clock  = 1'b0;
        reset  = 1'b0;
        bus1.reqValid = 1'b0; bus1.reqOp = '0; bus1.reqA = '0; bus1.reqB = '0; bus1.reqImm = '0;
        bus1.dataC = '0; bus1.zero = 1'b0; bus1.overflow = 1'b0; bus1.error = 1'b0; bus1.rspReady = 1'b0;
        bus4.reqValid = 1'b0; bus4.reqOp = '0; bus4.reqA = '0; bus4.reqB = '0; bus4.reqImm = '0;
        bus4.dataC = '0; bus4.zero = 1'b0; bus4.overflow = 1'b0; bus4.error = 1'b0; bus4.rspReady = 1'b0;
`ifdef ALU_SEQ_STICKY_EN
        stickyClr1 = 1'b0;
        stickyClr4 = 1'b0;
`endif
        @(negedge clock);
        test_reset();
        test_add();
        test_immediate();
        test_illegal();
        test_backpressure();
        test_settle4();
        test_reset_mid_settle();
        test_reset_in_resp();
`ifdef ALU_SEQ_STICKY_EN
        test_sticky();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
